// File: rtl/mac_tx_sched.sv
// -----------------------------------------------------------------------------
// mac_tx_sched
// Two-source transmit scheduler for a MAC line interface. Frames from the two
// sources are arbitrated round-robin and then sent beat by beat onto a single
// line. Start, terminate and idle control beats are added, and a minimum
// inter-packet gap is enforced. Any frame that underruns, is cancelled, or
// exceeds MAX_BEATS is closed with a terminate beat that has cancel_o set.
//
// Ports
//   clk, nreset            clock, asynchronous active-low reset
//   s_valid_i[n]           source n has a beat
//   s_data_i               source n data at [n*DATA_W +: DATA_W]
//   s_keep_i               source n byte enables at [n*KEEP_W +: KEEP_W]
//   s_last_i[n]            source n last beat of frame
//   s_cancel_i[n]          source n aborts its frame in flight
//   s_ready_o[n]           beat accepted from source n (combinational)
//   valid_o .. grant_o     registered line outputs (one cycle after accept)
// -----------------------------------------------------------------------------
module mac_tx_sched #(
    parameter int DATA_W    = 16,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int IPG_CYC   = 6,
    parameter int MAX_BEATS = 768
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [1:0]          s_valid_i,
    input  logic [2*DATA_W-1:0] s_data_i,
    input  logic [2*KEEP_W-1:0] s_keep_i,
    input  logic [1:0]          s_last_i,
    input  logic [1:0]          s_cancel_i,
    output logic [1:0]          s_ready_o,
    output logic                valid_o,
    output logic [DATA_W-1:0]   data_o,
    output logic                ctrl_v_o,
    output logic                idle_o,
    output logic                start_o,
    output logic                term_o,
    output logic [KEEP_W-1:0]   term_keep_o,
    output logic                cancel_o,
    output logic [1:0]          grant_o
);

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_IFG} state_t;

    localparam int               IFG_W    = (IPG_CYC > 1) ? $clog2(IPG_CYC) : 1;
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IPG_CYC - 1);
    localparam logic [9:0]       CNT_LAST = 10'(MAX_BEATS - 1);

    state_t             state_q, state_d;
    logic               rr_q, rr_d;          // source preferred on the next tie
    logic               own_q, own_d;        // index of the source owning the frame
    logic [9:0]         beat_cnt_q, beat_cnt_d;
    logic [IFG_W-1:0]   ifg_cnt_q, ifg_cnt_d;

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               ctrl_v_q, ctrl_v_d;
    logic               idle_q, idle_d;
    logic               start_q, start_d;
    logic               term_q, term_d;
    logic [KEEP_W-1:0]  term_keep_q, term_keep_d;
    logic               cancel_q, cancel_d;
    logic [1:0]         grant_q, grant_d;

    logic               win_idx;
    logic               cur_idx;
    logic [1:0]         cur_onehot;
    logic [DATA_W-1:0]  cur_data;
    logic [KEEP_W-1:0]  cur_keep;
    logic [9:0]         cur_cnt;
    logic               active;
    logic [1:0]         ready_c;

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        // Round-robin matters only when both sources request at once. A lone requester always wins.
        win_idx    = (s_valid_i == 2'b11) ? rr_q : s_valid_i[1];
        // The first beat is accepted in IDLE in the same cycle the grant is decided.
        cur_idx    = (state_q == S_PKT) ? own_q : win_idx;
        cur_onehot = cur_idx ? 2'b10 : 2'b01;
        cur_data   = cur_idx ? s_data_i[2*DATA_W-1:DATA_W] : s_data_i[DATA_W-1:0];
        cur_keep   = cur_idx ? s_keep_i[2*KEEP_W-1:KEEP_W] : s_keep_i[KEEP_W-1:0];
        cur_cnt    = (state_q == S_PKT) ? beat_cnt_q : 10'd0;
        active     = (state_q == S_PKT) || ((state_q == S_IDLE) && (|s_valid_i));

        state_d    = state_q;
        rr_d       = rr_q;
        own_d      = own_q;
        beat_cnt_d = beat_cnt_q;
        ifg_cnt_d  = ifg_cnt_q;
        ready_c    = 2'b00;

        // By default the line carries an idle control beat.
        valid_d     = 1'b1;
        data_d      = '0;
        ctrl_v_d    = 1'b1;
        idle_d      = 1'b1;
        start_d     = 1'b0;
        term_d      = 1'b0;
        term_keep_d = '0;
        cancel_d    = 1'b0;
        grant_d     = 2'b00;

        if (state_q == S_IFG) begin
            if (ifg_cnt_q == IFG_LAST) begin
                state_d   = S_IDLE;
                ifg_cnt_d = '0;
            end else begin
                ifg_cnt_d = ifg_cnt_q + 1'b1;
            end
        end else if (active) begin
            ready_c = cur_onehot;
            grant_d = cur_onehot;
            idle_d  = 1'b0;
            if (state_q == S_IDLE) begin
                own_d = win_idx;
                rr_d  = ~win_idx;
            end
            if ((state_q == S_PKT) && (s_cancel_i[cur_idx] || !s_valid_i[cur_idx])) begin
                // Abort: an empty terminate beat is sent, and the payload of this cycle is discarded.
                term_d   = 1'b1;
                cancel_d = 1'b1;
                state_d  = S_IFG;
            end else begin
                data_d     = cur_data;
                beat_cnt_d = cur_cnt + 10'd1;
                start_d    = (state_q == S_IDLE);
                state_d    = S_PKT;
                if (s_last_i[cur_idx]) begin
                    term_d      = 1'b1;
                    term_keep_d = cur_keep;
                    state_d     = S_IFG;
                end else if (cur_cnt == CNT_LAST) begin
                    // The frame is too long. This beat is sent as a cancelled terminate.
                    term_d   = 1'b1;
                    cancel_d = 1'b1;
                    state_d  = S_IFG;
                end
                ctrl_v_d = start_d | term_d;
            end
            if (state_d == S_IFG) begin
                ifg_cnt_d = '0;
            end
        end
    end

    // Gated by reset so that no beat is accepted while the block is held in reset.
    assign s_ready_o = ready_c & {2{nreset}};

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            own_q       <= 1'b0;
            beat_cnt_q  <= '0;
            ifg_cnt_q   <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            ctrl_v_q    <= 1'b0;
            idle_q      <= 1'b0;
            start_q     <= 1'b0;
            term_q      <= 1'b0;
            term_keep_q <= '0;
            cancel_q    <= 1'b0;
            grant_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            own_q       <= own_d;
            beat_cnt_q  <= beat_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            ctrl_v_q    <= ctrl_v_d;
            idle_q      <= idle_d;
            start_q     <= start_d;
            term_q      <= term_d;
            term_keep_q <= term_keep_d;
            cancel_q    <= cancel_d;
            grant_q     <= grant_d;
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign ctrl_v_o    = ctrl_v_q;
    assign idle_o      = idle_q;
    assign start_o     = start_q;
    assign term_o      = term_q;
    assign term_keep_o = term_keep_q;
    assign cancel_o    = cancel_q;
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_mac_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_mac_tx_sched
// Directed testbench for mac_tx_sched with DATA_W=16, IPG_CYC=6 and MAX_BEATS=4.
// Each vector applies input values for one cycle. It gives the expected
// s_ready_o for that cycle and the expected line beat on the next cycle.
// Line beat packing: {valid, ctrl_v, idle, start, term, term_keep, cancel, grant, data}.
// -----------------------------------------------------------------------------
module tb_mac_tx_sched;

    logic        clk = 1'b0;
    logic        nreset;
    logic [1:0]  s_valid_i;
    logic [31:0] s_data_i;
    logic [3:0]  s_keep_i;
    logic [1:0]  s_last_i;
    logic [1:0]  s_cancel_i;
    logic [1:0]  s_ready_o;
    logic        valid_o;
    logic [15:0] data_o;
    logic        ctrl_v_o;
    logic        idle_o;
    logic        start_o;
    logic        term_o;
    logic [1:0]  term_keep_o;
    logic        cancel_o;
    logic [1:0]  grant_o;

    always #5 clk = ~clk;

    mac_tx_sched #(.DATA_W(16), .KEEP_W(2), .IPG_CYC(6), .MAX_BEATS(4)) dut (
        .clk(clk), .nreset(nreset),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_keep_i(s_keep_i),
        .s_last_i(s_last_i), .s_cancel_i(s_cancel_i), .s_ready_o(s_ready_o),
        .valid_o(valid_o), .data_o(data_o), .ctrl_v_o(ctrl_v_o), .idle_o(idle_o),
        .start_o(start_o), .term_o(term_o), .term_keep_o(term_keep_o),
        .cancel_o(cancel_o), .grant_o(grant_o)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  last;
        logic [1:0]  cancel;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  k0;
        logic [1:0]  k1;
        logic [1:0]  rdy;
        logic [25:0] line;
    } vec_t;

    vec_t vecs[$];

    localparam logic [25:0] IDL = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 16'h0000};

    function automatic logic [25:0] beat(input logic st, input logic ct, input logic tm,
                                         input logic [1:0] k, input logic cn,
                                         input logic [1:0] g, input logic [15:0] d);
        return {1'b1, ct, 1'b0, st, tm, k, cn, g, d};
    endfunction

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] last,
                                input logic [1:0] cancel, input logic [15:0] d0,
                                input logic [15:0] d1, input logic [1:0] k0,
                                input logic [1:0] k1, input logic [1:0] rdy,
                                input logic [25:0] line);
        vec_t x;
        x.v = v; x.last = last; x.cancel = cancel; x.d0 = d0; x.d1 = d1;
        x.k0 = k0; x.k1 = k1; x.rdy = rdy; x.line = line;
        return x;
    endfunction

    function automatic logic [25:0] obs();
        return {valid_o, ctrl_v_o, idle_o, start_o, term_o, term_keep_o, cancel_o, grant_o, data_o};
    endfunction

    task automatic add(input int n, input vec_t x);
        for (int i = 0; i < n; i++) vecs.push_back(x);
    endtask

    task automatic apply(input vec_t x);
        s_valid_i  = x.v;
        s_last_i   = x.last;
        s_cancel_i = x.cancel;
        s_data_i   = {x.d1, x.d0};
        s_keep_i   = {x.k1, x.k0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        apply(mk(2'b11, 2'b00, 2'b00, 16'h1111, 16'h2222, 2'b11, 2'b11, 2'b00, IDL));
        step(); step(); step();
        checks++;
        if (obs() !== 26'h0) begin
            failures++; $display("FAIL reset_line: got %h want %h", obs(), 26'h0);
        end
        checks++;
        if (s_ready_o !== 2'b00) begin
            failures++; $display("FAIL reset_ready: got %b want 00", s_ready_o);
        end
        apply(mk(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00, IDL));
        nreset = 1'b1;
        #1;
        checks++;
        if (s_ready_o !== 2'b00) begin
            failures++; $display("FAIL reset_release_ready: got %b want 00", s_ready_o);
        end
        step();
        checks++;
        if (obs() !== IDL) begin
            failures++; $display("FAIL reset_first_idle: got %h want %h", obs(), IDL);
        end
    endtask

    task automatic test_contention();
        vecs.delete();
        add(1, mk(2'b11, 2'b00, 2'b00, 16'h0A01, 16'h0B01, 2'b00, 2'b00, 2'b01, beat(1, 1, 0, 2'b00, 0, 2'b01, 16'h0A01)));
        add(1, mk(2'b11, 2'b01, 2'b00, 16'h0A02, 16'h0B01, 2'b01, 2'b00, 2'b01, beat(0, 1, 1, 2'b01, 0, 2'b01, 16'h0A02)));
        add(6, mk(2'b11, 2'b01, 2'b00, 16'h0C01, 16'h0B01, 2'b11, 2'b00, 2'b00, IDL));
        add(1, mk(2'b11, 2'b01, 2'b00, 16'h0C01, 16'h0B01, 2'b11, 2'b00, 2'b10, beat(1, 1, 0, 2'b00, 0, 2'b10, 16'h0B01)));
        add(1, mk(2'b11, 2'b11, 2'b00, 16'h0C01, 16'h0B02, 2'b11, 2'b10, 2'b10, beat(0, 1, 1, 2'b10, 0, 2'b10, 16'h0B02)));
        add(6, mk(2'b01, 2'b01, 2'b00, 16'h0C01, 16'h0000, 2'b11, 2'b00, 2'b00, IDL));
        add(1, mk(2'b01, 2'b01, 2'b00, 16'h0C01, 16'h0000, 2'b11, 2'b00, 2'b01, beat(1, 1, 1, 2'b11, 0, 2'b01, 16'h0C01)));
        add(6, mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, IDL));
        foreach (vecs[i]) begin
            apply(vecs[i]); #1;
            checks++;
            if (s_ready_o !== vecs[i].rdy) begin
                failures++; $display("FAIL contention_ready[%0d]: got %b want %b", i, s_ready_o, vecs[i].rdy);
            end
            step();
            checks++;
            if (obs() !== vecs[i].line) begin
                failures++; $display("FAIL contention_line[%0d]: got %h want %h", i, obs(), vecs[i].line);
            end
        end
    endtask

    task automatic test_single_frame();
        vecs.delete();
        add(1, mk(2'b01, 2'b00, 2'b00, 16'hAA01, 16'h0, 2'b00, 2'b00, 2'b01, beat(1, 1, 0, 2'b00, 0, 2'b01, 16'hAA01)));
        add(1, mk(2'b01, 2'b00, 2'b00, 16'h1234, 16'h0, 2'b00, 2'b00, 2'b01, beat(0, 0, 0, 2'b00, 0, 2'b01, 16'h1234)));
        add(1, mk(2'b01, 2'b01, 2'b00, 16'h5678, 16'h0, 2'b11, 2'b00, 2'b01, beat(0, 1, 1, 2'b11, 0, 2'b01, 16'h5678)));
        add(7, mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0, 2'b00, 2'b00, 2'b00, IDL));
        foreach (vecs[i]) begin
            apply(vecs[i]); #1;
            checks++;
            if (s_ready_o !== vecs[i].rdy) begin
                failures++; $display("FAIL single_ready[%0d]: got %b want %b", i, s_ready_o, vecs[i].rdy);
            end
            step();
            checks++;
            if (obs() !== vecs[i].line) begin
                failures++; $display("FAIL single_line[%0d]: got %h want %h", i, obs(), vecs[i].line);
            end
        end
    endtask

    task automatic test_underrun();
        vecs.delete();
        add(1, mk(2'b01, 2'b00, 2'b00, 16'h0D01, 16'h0000, 2'b00, 2'b00, 2'b01, beat(1, 1, 0, 2'b00, 0, 2'b01, 16'h0D01)));
        add(1, mk(2'b11, 2'b10, 2'b00, 16'h0D02, 16'h0E01, 2'b00, 2'b01, 2'b01, beat(0, 0, 0, 2'b00, 0, 2'b01, 16'h0D02)));
        add(1, mk(2'b10, 2'b10, 2'b00, 16'h0000, 16'h0E01, 2'b00, 2'b01, 2'b01, beat(0, 1, 1, 2'b00, 1, 2'b01, 16'h0000)));
        add(6, mk(2'b10, 2'b10, 2'b00, 16'h0000, 16'h0E01, 2'b00, 2'b01, 2'b00, IDL));
        add(1, mk(2'b10, 2'b10, 2'b00, 16'h0000, 16'h0E01, 2'b00, 2'b01, 2'b10, beat(1, 1, 1, 2'b01, 0, 2'b10, 16'h0E01)));
        add(6, mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, IDL));
        foreach (vecs[i]) begin
            apply(vecs[i]); #1;
            checks++;
            if (s_ready_o !== vecs[i].rdy) begin
                failures++; $display("FAIL underrun_ready[%0d]: got %b want %b", i, s_ready_o, vecs[i].rdy);
            end
            step();
            checks++;
            if (obs() !== vecs[i].line) begin
                failures++; $display("FAIL underrun_line[%0d]: got %h want %h", i, obs(), vecs[i].line);
            end
        end
    endtask

    task automatic test_overflow();
        vecs.delete();
        add(1, mk(2'b10, 2'b00, 2'b00, 16'h0, 16'h0F01, 2'b00, 2'b11, 2'b10, beat(1, 1, 0, 2'b00, 0, 2'b10, 16'h0F01)));
        add(1, mk(2'b10, 2'b00, 2'b00, 16'h0, 16'h0F02, 2'b00, 2'b11, 2'b10, beat(0, 0, 0, 2'b00, 0, 2'b10, 16'h0F02)));
        add(1, mk(2'b10, 2'b00, 2'b00, 16'h0, 16'h0F03, 2'b00, 2'b11, 2'b10, beat(0, 0, 0, 2'b00, 0, 2'b10, 16'h0F03)));
        add(1, mk(2'b10, 2'b00, 2'b00, 16'h0, 16'h0F04, 2'b00, 2'b11, 2'b10, beat(0, 1, 1, 2'b00, 1, 2'b10, 16'h0F04)));
        add(6, mk(2'b10, 2'b00, 2'b00, 16'h0, 16'h0F05, 2'b00, 2'b11, 2'b00, IDL));
        add(1, mk(2'b00, 2'b00, 2'b00, 16'h0, 16'h0000, 2'b00, 2'b00, 2'b00, IDL));
        foreach (vecs[i]) begin
            apply(vecs[i]); #1;
            checks++;
            if (s_ready_o !== vecs[i].rdy) begin
                failures++; $display("FAIL overflow_ready[%0d]: got %b want %b", i, s_ready_o, vecs[i].rdy);
            end
            step();
            checks++;
            if (obs() !== vecs[i].line) begin
                failures++; $display("FAIL overflow_line[%0d]: got %h want %h", i, obs(), vecs[i].line);
            end
        end
    endtask

    task automatic test_cancel_last();
        vecs.delete();
        add(1, mk(2'b01, 2'b00, 2'b10, 16'h1001, 16'h0, 2'b00, 2'b00, 2'b01, beat(1, 1, 0, 2'b00, 0, 2'b01, 16'h1001)));
        add(1, mk(2'b01, 2'b00, 2'b10, 16'h1002, 16'h0, 2'b00, 2'b00, 2'b01, beat(0, 0, 0, 2'b00, 0, 2'b01, 16'h1002)));
        add(1, mk(2'b01, 2'b01, 2'b01, 16'h1003, 16'h0, 2'b11, 2'b00, 2'b01, beat(0, 1, 1, 2'b00, 1, 2'b01, 16'h0000)));
        add(6, mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0, 2'b00, 2'b00, 2'b00, IDL));
        foreach (vecs[i]) begin
            apply(vecs[i]); #1;
            checks++;
            if (s_ready_o !== vecs[i].rdy) begin
                failures++; $display("FAIL cancel_last_ready[%0d]: got %b want %b", i, s_ready_o, vecs[i].rdy);
            end
            step();
            checks++;
            if (obs() !== vecs[i].line) begin
                failures++; $display("FAIL cancel_last_line[%0d]: got %h want %h", i, obs(), vecs[i].line);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [25:0] exp_line;
        apply(mk(2'b01, 2'b00, 2'b00, 16'h2001, 16'h0, 2'b00, 2'b00, 2'b00, IDL));
        step();
        exp_line = beat(1, 1, 0, 2'b00, 0, 2'b01, 16'h2001);
        checks++;
        if (obs() !== exp_line) begin
            failures++; $display("FAIL rstmid_start: got %h want %h", obs(), exp_line);
        end
        apply(mk(2'b01, 2'b00, 2'b00, 16'h2002, 16'h0, 2'b00, 2'b00, 2'b00, IDL));
        step();
        exp_line = beat(0, 0, 0, 2'b00, 0, 2'b01, 16'h2002);
        checks++;
        if (obs() !== exp_line) begin
            failures++; $display("FAIL rstmid_beat2: got %h want %h", obs(), exp_line);
        end
        apply(mk(2'b01, 2'b00, 2'b00, 16'h2003, 16'h0, 2'b00, 2'b00, 2'b00, IDL));
        nreset = 1'b0;
        #1;
        checks++;
        if (obs() !== 26'h0) begin
            failures++; $display("FAIL rstmid_low_line: got %h want %h", obs(), 26'h0);
        end
        checks++;
        if (s_ready_o !== 2'b00) begin
            failures++; $display("FAIL rstmid_low_ready: got %b want 00", s_ready_o);
        end
        step(); step();
        checks++;
        if (obs() !== 26'h0) begin
            failures++; $display("FAIL rstmid_held_line: got %h want %h", obs(), 26'h0);
        end
        apply(mk(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00, IDL));
        nreset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (obs() !== IDL) begin
                failures++; $display("FAIL rstmid_idle[%0d]: got %h want %h", i, obs(), IDL);
            end
        end
        // The pointer must be back at source 0, so source 0 wins a tie.
        apply(mk(2'b11, 2'b00, 2'b00, 16'h3001, 16'h3101, 2'b00, 2'b00, 2'b00, IDL));
        #1;
        checks++;
        if (s_ready_o !== 2'b01) begin
            failures++; $display("FAIL rstmid_rr_ready: got %b want 01", s_ready_o);
        end
        step();
        exp_line = beat(1, 1, 0, 2'b00, 0, 2'b01, 16'h3001);
        checks++;
        if (obs() !== exp_line) begin
            failures++; $display("FAIL rstmid_rr_start: got %h want %h", obs(), exp_line);
        end
        apply(mk(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00, IDL));
        repeat (10) step();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_frame();
        test_underrun();
        test_overflow();
        test_cancel_last();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
